// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage; drives the pipeline stall request.
// Optional signed support (DIV) is built only when DIV_SIGNED_EN is defined.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PART_W = 2*WIDTH + 1;

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  logic [1:0]         r_state,   w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [PART_W-1:0]  r_part,    w_part_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic               r_neg_q,   w_neg_q_nxt;
  logic               r_neg_r,   w_neg_r_nxt;
  logic               r_ready,   w_ready_nxt;
  logic [2*WIDTH-1:0] r_result,  w_result_nxt;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg_q_in;
  logic               w_neg_r_in;
  logic [PART_W:0]    w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic [PART_W-1:0]  w_part_step;
  logic [WIDTH-1:0]   w_quot_fin;
  logic [WIDTH-1:0]   w_rem_fin;

`ifdef DIV_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;

  assign w_neg_a    = signed_div_i & opdata1_i[WIDTH-1];
  assign w_neg_b    = signed_div_i & opdata2_i[WIDTH-1];
  assign w_mag_a    = w_neg_a ? -opdata1_i : opdata1_i;
  assign w_mag_b    = w_neg_b ? -opdata2_i : opdata2_i;
  assign w_neg_q_in = w_neg_a ^ w_neg_b;
  assign w_neg_r_in = w_neg_a;
  // Quotient negated on sign mismatch; remainder follows the dividend.
  assign w_quot_fin = r_neg_q ? -w_part_step[WIDTH-1:0]       : w_part_step[WIDTH-1:0];
  assign w_rem_fin  = r_neg_r ? -w_part_step[2*WIDTH-1:WIDTH] : w_part_step[2*WIDTH-1:WIDTH];
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div_i ^ r_neg_q ^ r_neg_r;
  assign w_mag_a         = opdata1_i;
  assign w_mag_b         = opdata2_i;
  assign w_neg_q_in      = 1'b0;
  assign w_neg_r_in      = 1'b0;
  assign w_quot_fin      = w_part_step[WIDTH-1:0];
  assign w_rem_fin       = w_part_step[2*WIDTH-1:WIDTH];
`endif

  // One restoring step: shift, trial-subtract from the upper bits, keep or restore.
  assign w_shift     = {r_part, 1'b0};
  assign w_trial     = w_shift[PART_W:WIDTH] - {2'b00, r_divisor};
  assign w_part_step = w_trial[WIDTH+1] ? w_shift[PART_W-1:0]
                                        : {w_trial[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_part_nxt    = r_part;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_ready_nxt   = r_ready;
    w_result_nxt  = r_result;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt   = S_ON;
            w_part_nxt    = {(WIDTH+1)'(0), w_mag_a};
            w_divisor_nxt = w_mag_b;
            w_neg_q_nxt   = w_neg_q_in;
            w_neg_r_nxt   = w_neg_r_in;
            w_cnt_nxt     = '0;
          end
        end
      end
      S_BYZERO: begin
        w_state_nxt  = S_END;
        w_ready_nxt  = 1'b1;
        w_result_nxt = '0;
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
        end else begin
          w_part_nxt = w_part_step;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            w_state_nxt  = S_END;
            w_ready_nxt  = 1'b1;
            w_result_nxt = {w_rem_fin, w_quot_fin};
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_part    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_part    <= w_part_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_ready   <= w_ready_nxt;
      r_result  <= w_result_nxt;
    end
  end

  assign ready_o    = r_ready;
  assign result_o   = r_result;
  assign stallreq_o = start_i && !r_ready;

endmodule
